// File: rtl/q_exit_buf.sv
// q_exit_buf: result-select mux feeding a registered FIFO exit buffer with a sticky overflow flag.
module q_exit_buf #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N:0]               QD,
  input  logic [N:0]               QM,
  input  logic [N:0]               QR1,
  input  logic [N:0]               QR0,
  input  logic [1:0]               op,
  input  logic                     msb_aq,
  input  logic                     done,
  input  logic                     out_ready,
  output logic [N:0]               out,
  output logic [1:0]               out_op,
  output logic                     out_err,
  output logic                     out_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [N+3:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [N:0]    w_sel;
  logic [N+3:0]  w_head;
  logic          w_pop;
  logic          w_push;
  assign w_sel     = op == 2'b00 ? QM : op == 2'b01 ? QD : op == 2'b10 ? (msb_aq ? QR0 : QR1) : '0;
  assign out_valid = r_cnt != '0;
  assign full      = r_cnt == CW'(DEPTH);
  assign count     = r_cnt;
  assign ovf       = r_ovf;
  assign w_pop     = out_valid & out_ready;
  // a full buffer still accepts when the head leaves in the same cycle
  assign w_push    = done & (~full | w_pop);
  assign w_head    = r_mem[r_rp];
  assign out       = out_valid ? w_head[N+3:3] : '0;
  assign out_op    = out_valid ? w_head[2:1] : '0;
  assign out_err   = out_valid & w_head[0];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {w_sel, op, &op};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (done & ~w_push) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_q_exit_buf.sv
// tb_q_exit_buf: randomized and directed scoreboard bench for q_exit_buf (N=4, DEPTH=2).
module tb_q_exit_buf;
  localparam int N = 4;
  localparam int DEPTH = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [N:0] QD = '0, QM = '0, QR1 = '0, QR0 = '0;
  logic [1:0] op = '0;
  logic       msb_aq = 1'b0, done = 1'b0, out_ready = 1'b0;
  logic [N:0] out;
  logic [1:0] out_op;
  logic       out_err, out_valid, full, ovf;
  logic [$clog2(DEPTH):0] count;
  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  int mcount = 0;
  logic movf = 1'b0;

  q_exit_buf #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .QD(QD), .QM(QM), .QR1(QR1), .QR0(QR0), .op(op),
    .msb_aq(msb_aq), .done(done), .out_ready(out_ready), .out(out), .out_op(out_op),
    .out_err(out_err), .out_valid(out_valid), .full(full), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] entry(input logic [1:0] o, input logic [4:0] qm, qd, qr1, qr0, input logic m);
    logic [4:0] v;
    case (o)
      2'b00: v = qm;
      2'b01: v = qd;
      2'b10: v = m ? qr0 : qr1;
      default: v = 5'd0;
    endcase
    return {v, o, o == 2'b11};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle: drive inputs, check status against the model before the edge, advance the model
  task automatic cyc(input logic d, input logic [1:0] o, input logic [4:0] qm, qd, qr1, qr0,
                     input logic m, input logic rdy, input logic r);
    bit pop, push;
    done = d; op = o; QM = qm; QD = qd; QR1 = qr1; QR0 = qr0; msb_aq = m; out_ready = rdy; rst = r;
    @(negedge clk);
    chk("count", int'(count), mcount);
    chk("out_valid", int'(out_valid), int'(mcount != 0));
    chk("full", int'(full), int'(mcount == DEPTH));
    chk("ovf", int'(ovf), int'(movf));
    if (r) begin
      mcount = 0;
      movf = 1'b0;
      sb.delete();
    end else begin
      pop = mcount > 0 && rdy;
      push = d && (mcount < DEPTH || pop);
      if (push) sb.push_back(entry(o, qm, qd, qr1, qr0, m));
      if (d && !push) movf = 1'b1;
      mcount = mcount + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_qm(input logic [4:0] v, input logic rdy);
    cyc(1'b1, 2'b00, v, 5'h1F, 5'h1E, 5'h1D, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, rdy, 1'b0);
  endtask

  // monitor: head must match the scoreboard front whenever valid, and be zero when empty
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL head: out_valid=1 but nothing expected at %0t", $time);
        end else begin
          if ({out, out_op, out_err} !== sb[0]) begin
            bad++;
            $display("FAIL head: got %h expected %h at %0t", {out, out_op, out_err}, sb[0], $time);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        total++;
        if ({out, out_op, out_err} !== 8'h00) begin
          bad++;
          $display("FAIL idle_out: got %h expected 00 at %0t", {out, out_op, out_err}, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle(1'b0);
    // mux selection, one done per case, consumer always ready
    cyc(1'b1, 2'b00, 5'h13, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b1, 2'b01, 5'h00, 5'h07, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b1, 2'b10, 5'h00, 5'h00, 5'h04, 5'h03, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b1, 2'b10, 5'h00, 5'h00, 5'h04, 5'h03, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b1, 2'b11, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    // latency into empty buffer
    idle(1'b0);
    push_qm(5'h0A, 1'b0);
    idle(1'b1);
    idle(1'b1);
    // fill and overflow
    push_qm(5'h01, 1'b0);
    push_qm(5'h02, 1'b0);
    push_qm(5'h03, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    // full with simultaneous pop, after clearing ovf
    cyc(1'b0, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
    push_qm(5'h01, 1'b0);
    push_qm(5'h02, 1'b0);
    push_qm(5'h03, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    // wrap-around with push/pop pairs
    for (int i = 0; i < 7; i++) push_qm(5'(5'h10 + i), 1'b1);
    idle(1'b1);
    // reset mid-operation while full with done asserted
    push_qm(5'h05, 1'b0);
    push_qm(5'h06, 1'b0);
    cyc(1'b1, 2'b00, 5'h07, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 2), 2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 1'($urandom % 2), 1'(($urandom % 3) != 0), 1'(($urandom % 64) == 0));
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
